step_down_counter: RTL and testbench
====================================

# step_down_counter

Loadable synchronous down-counter that counts in the opposite direction to the team's ripple up-counter. It is used as the step/iteration counter of the sequential multiplier: the controller loads an iteration count, the block decrements once per enabled cycle, then flags the terminal count. It is fully synchronous on one clock, with a ready/valid load handshake, optional auto-reload, and an abort input.

## Interface

- WIDTH, default 4: counter and load-value width in bits; legal range is 2 or more.

- clk  in  1  sole clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the clk rising edge.
- load_valid  in  1  controller offers load_value.
- load_ready  out  1  block accepts a load; high exactly when the state is IDLE.
- load_value  in  WIDTH  start count, captured on handshake.
- auto_reload  in  1  sampled on each terminal-count cycle; 1 = reload and keep running.
- en  in  1  count enable; 0 = hold, only meaningful in RUN.
- stop  in  1  abort; in RUN, return to IDLE.
- count_out  out  WIDTH  current count value.
- busy  out  1  high while in RUN.
- tc  out  1  one-cycle terminal-count pulse.
- done  out  1  one-cycle pulse when a run ends naturally.

## Operation

- Two states, IDLE and RUN.
- Reset forces every register to the following values, and reset has priority over all other inputs:
  - state = IDLE, so load_ready = 1
  - count_out = 0
  - reload register = 0
  - busy = 0, tc = 0, done = 0
- **IDLE**
  - load_valid && load_ready: count_out and the reload register take load_value; the next state is RUN.
  - en, stop and auto_reload are ignored in IDLE.
- **RUN, checked in this priority order**
  1. stop = 1: go to IDLE. count_out holds its value. No tc, no done.
  2. en = 0: hold everything.
  3. en = 1 and count_out != 0: count_out decrements by 1.
  4. en = 1 and count_out == 0: tc pulses on the next cycle, and then:
     - if auto_reload = 1: count_out takes the reload register value and the block stays in RUN;
     - if auto_reload = 0: go to IDLE, done pulses on the next cycle, and count_out stays 0.
- A load of N therefore produces its terminal event after N+1 enabled cycles.
- A load of 0 gives a terminal event on the first enabled cycle. With auto_reload = 1 it produces tc on every enabled cycle.
- Decrement is modulo-free: the block never wraps below 0, because the count == 0 case has priority over decrement.
- load_valid while in RUN is not accepted and load_value is ignored; the controller must hold load_valid high until the handshake completes.
- tc and done are not sticky; each is cleared on the following cycle.

## Timing

- All outputs are registered, except load_ready, which is decoded from the state register.
- Load latency is 1 cycle: handshake at edge k, so count_out = load_value and busy = 1 after edge k.
- Decrement latency is 1 cycle per enabled edge.
- tc and done assert in the cycle after the edge that sampled count == 0 with en = 1. At that point the state is already IDLE, when returning to IDLE.
- A new load is accepted in the same cycle that done is high. The back-to-back gap from terminal edge to the next load edge is 1 cycle.
- Synchronous reset asserted mid-run: after that edge the block is idle, count_out = 0, and no tc/done pulse is produced.

## Structure

- Shared package step_counter_pkg holds:
  - the state enum typedef (IDLE, RUN);
  - the default width constant, STEP_CNT_W = 4.
- Single module with no sub-modules: the decrement is one subtractor and the FSM has two states.
- One always block for the registers and one for next-state/decode are sufficient.

## Test plan

- Reset, then load 3 with en = 1 and auto_reload = 0: count_out runs 3,2,1,0, then tc = done = 1 for one cycle, busy drops, and load_ready = 1.
- Load 2 with en toggling 1,0,1,0,1: count decrements only on en = 1 cycles, and tc follows the third enabled cycle.
- Load 1 with auto_reload = 1 and en held high: count_out cycles 1,0,1,0 with tc every 2 cycles, done is never asserted, and busy stays 1.
- Load 5, then assert stop at count 3 together with load_valid: the block returns to IDLE with count_out = 3 and no tc/done. The next cycle, load 7 is accepted.
- Load 0 with auto_reload = 0: tc and done pulse after the first enabled cycle. A second load presented during done is accepted immediately.
- Load 6, then assert reset at count 4: the next cycle shows count_out = 0, busy = 0, tc = done = 0, and load_ready = 1.

Source files
------------

// File: rtl/step_counter_pkg.sv
// Shared definitions for the step/iteration down-counter.
//   step_state_t : two-state controller encoding (IDLE, RUN)
//   STEP_CNT_W   : default counter width
package step_counter_pkg;

  localparam int unsigned STEP_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } step_state_t;

endpackage

// File: rtl/step_down_counter.sv
// Loadable synchronous down-counter used as the iteration counter of the
// sequential multiplier. A load is taken through a ready/valid handshake
// while idle. Each enabled cycle in RUN decrements the count. At count == 0,
// an enabled cycle flags terminal count and then either reloads or ends the run.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   load_valid  in   controller offers load_value
//   load_ready  out  load accepted this cycle (state == IDLE, decoded)
//   load_value  in   start count, captured on handshake
//   auto_reload in   on terminal count: 1 = reload and keep running
//   en          in   count enable (RUN only)
//   stop        in   abort run back to IDLE (RUN only)
//   count_out   out  current count (registered)
//   busy        out  high while in RUN (registered)
//   tc          out  one-cycle terminal-count pulse (registered)
//   done        out  one-cycle pulse when a run ends naturally (registered)
module step_down_counter
  import step_counter_pkg::*;
#(
  parameter int unsigned WIDTH = STEP_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             en,
  input  logic             stop,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  step_state_t      state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic             tc_n, done_n;

  assign load_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count_out <= '0;
      reload    <= '0;
      busy      <= 1'b0;
      tc        <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      count_out <= count_n;
      reload    <= reload_n;
      busy      <= (state_n == RUN);
      tc        <= tc_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count_out;
    reload_n = reload;
    tc_n     = 1'b0;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_valid) begin
          count_n  = load_value;
          reload_n = load_value;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (en) begin
          // Zero check wins over decrement, so the count never wraps.
          if (count_out != '0) begin
            count_n = count_out - WIDTH'(1);
          end else begin
            tc_n = 1'b1;
            if (auto_reload) begin
              count_n = reload;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_step_down_counter.sv
// Scoreboard bench for step_down_counter. The stimulus process drives one
// cycle of inputs and pushes the hand-computed outputs expected after that
// edge. The monitor pops and compares each cycle, 1 time unit after the edge.
module tb_step_down_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [3:0] load_value = '0;
  logic       auto_reload = 1'b0;
  logic       en = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] count_out;
  logic       busy, tc, done;

  typedef struct packed {
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       done;
    logic       ready;
  } obs_t;

  typedef struct {
    string name;
    obs_t  obs;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  step_down_counter #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .en          (en),
    .stop        (stop),
    .count_out   (count_out),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Monitor: one comparison per edge for which an expectation is queued.
  initial begin
    exp_t e;
    obs_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = '{count: count_out, busy: busy, tc: tc, done: done, ready: load_ready};
        check_cnt++;
        if (act === e.obs) pass_cnt++;
        else
          $display("FAIL %s: got count=%0d busy=%b tc=%b done=%b ready=%b, expected count=%0d busy=%b tc=%b done=%b ready=%b",
                   e.name, act.count, act.busy, act.tc, act.done, act.ready,
                   e.obs.count, e.obs.busy, e.obs.tc, e.obs.done, e.obs.ready);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, got %0d/%0d", pass_cnt, check_cnt);
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input string nm, input logic r, input logic lv, input logic [3:0] lval,
                     input logic ar, input logic e_in, input logic s,
                     input logic [3:0] ec, input logic eb, input logic et,
                     input logic ed, input logic er);
    exp_t x;
    reset       = r;
    load_valid  = lv;
    load_value  = lval;
    auto_reload = ar;
    en          = e_in;
    stop        = s;
    x.name = nm;
    x.obs  = '{count: ec, busy: eb, tc: et, done: ed, ready: er};
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  initial begin
    //   name          rst lv val ar en st   cnt busy tc done rdy
    cyc("reset",       1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1);
    cyc("idle_en",     0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 1);

    // Load 3, en high, no reload: 3,2,1,0 then tc+done.
    cyc("ld3",         0, 1, 3, 0, 1, 0,    3, 1, 0, 0, 0);
    cyc("ld3_c2",      0, 0, 0, 0, 1, 0,    2, 1, 0, 0, 0);
    cyc("ld3_c1",      0, 0, 0, 0, 1, 0,    1, 1, 0, 0, 0);
    cyc("ld3_c0",      0, 0, 0, 0, 1, 0,    0, 1, 0, 0, 0);
    cyc("ld3_tc",      0, 0, 0, 0, 1, 0,    0, 0, 1, 1, 1);
    cyc("ld3_clear",   0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 1);

    // Load 2 with en toggling 1,0,1,0,1.
    cyc("ld2",         0, 1, 2, 0, 0, 0,    2, 1, 0, 0, 0);
    cyc("ld2_en1a",    0, 0, 0, 0, 1, 0,    1, 1, 0, 0, 0);
    cyc("ld2_en0a",    0, 0, 0, 0, 0, 0,    1, 1, 0, 0, 0);
    cyc("ld2_en1b",    0, 0, 0, 0, 1, 0,    0, 1, 0, 0, 0);
    cyc("ld2_en0b",    0, 0, 0, 0, 0, 0,    0, 1, 0, 0, 0);
    cyc("ld2_tc",      0, 0, 0, 0, 1, 0,    0, 0, 1, 1, 1);

    // Load 1 with auto-reload: 1,0,1,0 with tc every second cycle, no done.
    cyc("ar1_ld",      0, 1, 1, 1, 1, 0,    1, 1, 0, 0, 0);
    cyc("ar1_c0",      0, 0, 0, 1, 1, 0,    0, 1, 0, 0, 0);
    cyc("ar1_tc1",     0, 0, 0, 1, 1, 0,    1, 1, 1, 0, 0);
    cyc("ar1_c0b",     0, 0, 0, 1, 1, 0,    0, 1, 0, 0, 0);
    cyc("ar1_tc2",     0, 0, 0, 1, 1, 0,    1, 1, 1, 0, 0);
    cyc("ar1_c0c",     0, 0, 0, 1, 1, 0,    0, 1, 0, 0, 0);
    // Stop at count 0 with en high: stop wins, no tc.
    cyc("ar1_stop",    0, 0, 0, 1, 1, 1,    0, 0, 0, 0, 1);

    // Load 5, stop at count 3 together with load_valid, then load 7.
    cyc("ld5",         0, 1, 5, 0, 1, 0,    5, 1, 0, 0, 0);
    cyc("ld5_c4",      0, 0, 0, 0, 1, 0,    4, 1, 0, 0, 0);
    cyc("ld5_c3",      0, 0, 0, 0, 1, 0,    3, 1, 0, 0, 0);
    cyc("ld5_stop",    0, 1, 7, 0, 1, 1,    3, 0, 0, 0, 1);
    cyc("ld7",         0, 1, 7, 0, 0, 0,    7, 1, 0, 0, 0);
    cyc("ld7_ignore",  0, 1, 9, 0, 0, 0,    7, 1, 0, 0, 0);
    cyc("ld7_stop",    0, 0, 0, 0, 0, 1,    7, 0, 0, 0, 1);

    // Load 0, no reload: terminal on first enabled cycle, reload during done.
    cyc("ld0",         0, 1, 0, 0, 0, 0,    0, 1, 0, 0, 0);
    cyc("ld0_tc",      0, 0, 0, 0, 1, 0,    0, 0, 1, 1, 1);
    cyc("ld4_in_done", 0, 1, 4, 0, 0, 0,    4, 1, 0, 0, 0);
    cyc("ld4_c3",      0, 0, 0, 0, 1, 0,    3, 1, 0, 0, 0);
    cyc("ld4_reset",   1, 0, 0, 0, 1, 0,    0, 0, 0, 0, 1);

    // Load 0 with auto-reload: tc on every enabled cycle.
    cyc("ar0_ld",      0, 1, 0, 1, 0, 0,    0, 1, 0, 0, 0);
    cyc("ar0_tc1",     0, 0, 0, 1, 1, 0,    0, 1, 1, 0, 0);
    cyc("ar0_tc2",     0, 0, 0, 1, 1, 0,    0, 1, 1, 0, 0);
    cyc("ar0_hold",    0, 0, 0, 1, 0, 0,    0, 1, 0, 0, 0);
    cyc("ar0_stop",    0, 0, 0, 1, 0, 1,    0, 0, 0, 0, 1);

    // Load 6, reset at count 4 (with en, load_valid asserted).
    cyc("ld6",         0, 1, 6, 0, 1, 0,    6, 1, 0, 0, 0);
    cyc("ld6_c5",      0, 0, 0, 0, 1, 0,    5, 1, 0, 0, 0);
    cyc("ld6_c4",      0, 0, 0, 0, 1, 0,    4, 1, 0, 0, 0);
    cyc("ld6_reset",   1, 1, 9, 0, 1, 0,    0, 0, 0, 0, 1);
    cyc("rst_vs_load", 1, 1, 9, 0, 1, 0,    0, 0, 0, 0, 1);
    cyc("post_reset",  0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 1);

    // Width boundary: load max value, first decrement.
    cyc("ld15",        0, 1, 15, 0, 1, 0,  15, 1, 0, 0, 0);
    cyc("ld15_c14",    0, 0, 0, 0, 1, 0,   14, 1, 0, 0, 0);

    reset      = 1'b0;
    load_valid = 1'b0;
    en         = 1'b0;
    stop       = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
